// File: rtl/mantissa_divider_seq.sv
// Sequential restoring divider for the FPU mantissa path: one quotient bit per
// cycle through a shared SIZE+1 bit subtractor, with a start/busy/done handshake.

module subtractor #(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         underflow
);
  assign {underflow, diff} = {1'b0, a} - {1'b0, b};
endmodule

module mantissa_divider_seq #(
  parameter int SIZE = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [SIZE:0]   r, d, t, diff, r_step;
  logic [SIZE-1:0] q, q_step;
  logic [CW-1:0]   count;
  logic            uf, last, zero;

  // R < D keeps the remainder MSB at 0, so it never feeds the next partial remainder
  logic unused_r_msb;
  assign unused_r_msb = r[SIZE];

  assign t      = {r[SIZE-1:0], q[SIZE-1]};
  assign r_step = uf ? t : diff;
  assign q_step = {q[SIZE-2:0], ~uf};
  assign last   = (count == LAST);
  assign zero   = (divisor == '0);

  subtractor #(.W(SIZE + 1)) u_sub (
    .a         (t),
    .b         (d),
    .diff      (diff),
    .underflow (uf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (last) state_nxt = DONE;
      default: begin
        if (start) state_nxt = zero ? DONE : RUN;
        else       state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r           <= '0;
      d           <= '0;
      q           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          r     <= r_step;
          q     <= q_step;
          count <= count + 1'b1;
          if (last) begin
            quotient    <= q_step;
            remainder   <= r_step[SIZE-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            if (zero) begin
              // divide by zero resolves in one cycle without touching the datapath
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r     <= '0;
              q     <= dividend;
              d     <= {1'b0, divisor};
              count <= '0;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
